if_id_fetch_stage: RTL

Instruction-fetch stage plus IF/ID pipeline register for the 5-stage MIPS pipeline. Holds the PC, drives the instruction-memory address, and latches fetched instruction and PC+4 into IF/ID. Consumes the load-use `hazard` stall from the hazard detection unit and the branch redirect from EX/MEM. Feeds IF/ID rs/rt back to the hazard unit and the instruction to the decode stage.

---
 rtl/if_id_fetch_stage_pkg.sv | 30 +++
 rtl/if_id_fetch_stage_pipe_reg_en_clr.sv | 38 +++
 rtl/if_id_fetch_stage.sv | 112 +++++++++++
 3 files changed

// File: rtl/if_id_fetch_stage_pkg.sv
// Shared constants for the fetch stage: instruction field positions, NOP encoding,
// the PC step, the default reset PC, and the per-cycle action encoding.
package if_id_fetch_stage_pkg;

  localparam int unsigned RS_HI = 25;
  localparam int unsigned RS_LO = 21;
  localparam int unsigned RT_HI = 20;
  localparam int unsigned RT_LO = 16;

  localparam logic [31:0] NOP_ENC      = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_STALL,
    ACT_FLUSH
  } fetch_act_e;

  // A redirect squashes the instruction in ID, so it outranks the load-use stall.
  function automatic fetch_act_e sel_action(input logic branch_taken, input logic hazard);
    if (branch_taken)
      return ACT_FLUSH;
    else if (hazard)
      return ACT_STALL;
    else
      return ACT_ADVANCE;
  endfunction

endpackage

// File: rtl/if_id_fetch_stage_pipe_reg_en_clr.sv
// Generic pipeline register: synchronous active-low reset, clear-to-value, and load enable.
// Priority is reset, then clear, then enable; otherwise the value holds.
module pipe_reg_en_clr
  import if_id_fetch_stage_pkg::*;
#(
  parameter int unsigned    W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic [W-1:0] clr_val_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] r_q;
  logic [W-1:0] r_d;

  always_comb begin
    r_d = r_q;
    if (clr_i)
      r_d = clr_val_i;
    else if (en_i)
      r_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i)
      r_q <= RST_VAL;
    else
      r_q <= r_d;
  end

  assign q_o = r_q;

endmodule

// File: rtl/if_id_fetch_stage.sv
// MIPS instruction-fetch stage with IF/ID register: PC, flush on taken branch,
// hold on load-use hazard, and saturating stall/flush counters.
module if_id_fetch_stage
  import if_id_fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_ENC,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hazard_i,
  input  logic             branch_taken_i,
  input  logic [31:0]      branch_target_i,
  output logic [31:0]      imem_addr_o,
  input  logic [31:0]      imem_data_i,
  output logic [31:0]      pc_o,
  output logic [31:0]      if_id_pc4_o,
  output logic [31:0]      if_id_instr_o,
  output logic [4:0]       if_id_rs_o,
  output logic [4:0]       if_id_rt_o,
  output logic             if_id_valid_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  fetch_act_e       act;
  logic             advance;
  logic             flush;
  logic [31:0]      pc_q;
  logic [31:0]      pc_plus4;
  logic [31:0]      target_aligned;
  logic [31:0]      if_id_instr_q;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    act            = sel_action(branch_taken_i, hazard_i);
    advance        = (act == ACT_ADVANCE);
    flush          = (act == ACT_FLUSH);
    pc_plus4       = pc_q + PC_INC;
    target_aligned = branch_target_i & ~32'h0000_0003;
  end

  pipe_reg_en_clr #(.W(32), .RST_VAL(RESET_PC)) u_pc (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (advance),
    .clr_i     (flush),
    .clr_val_i (target_aligned),
    .d_i       (pc_plus4),
    .q_o       (pc_q)
  );

  pipe_reg_en_clr #(.W(32), .RST_VAL(NOP_INSTR)) u_if_id_instr (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (advance),
    .clr_i     (flush),
    .clr_val_i (NOP_INSTR),
    .d_i       (imem_data_i),
    .q_o       (if_id_instr_q)
  );

  pipe_reg_en_clr #(.W(32), .RST_VAL(32'h0)) u_if_id_pc4 (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (advance),
    .clr_i     (flush),
    .clr_val_i (32'h0),
    .d_i       (pc_plus4),
    .q_o       (if_id_pc4_o)
  );

  pipe_reg_en_clr #(.W(1), .RST_VAL(1'b0)) u_if_id_valid (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .en_i      (advance),
    .clr_i     (flush),
    .clr_val_i (1'b0),
    .d_i       (1'b1),
    .q_o       (if_id_valid_o)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (act == ACT_STALL && stall_cnt_q != '1)
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && flush_cnt_q != '1)
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign pc_o          = pc_q;
  assign imem_addr_o   = pc_q;
  assign if_id_instr_o = if_id_instr_q;
  assign if_id_rs_o    = if_id_instr_q[RS_HI:RS_LO];
  assign if_id_rt_o    = if_id_instr_q[RT_HI:RT_LO];
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

endmodule
